// File: rtl/jtag_tdo_capture.sv
// jtag_tdo_capture: snoops master tck/tms and target tdo, tracks the 1149.1 TAP
// state and packs Shift-DR bits into DATA_DATA-bit words for a write FIFO.
// Ports: clk, rst (async active-low), tck/tms/tdo (snooped JTAG), clr (sync
// clear), wdata_data/wr_data/full_data (FIFO write side), tap_state,
// capturing, bit_count, overflow (status).
// Optional macro CAPTURE_IR_EN: also capture and flush in Shift-IR.
module jtag_tdo_capture #(
    parameter int DATA_DATA = 8,
    parameter int INIT_RTI  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tck,
    input  logic                 tms,
    input  logic                 tdo,
    input  logic                 clr,
    output logic [DATA_DATA-1:0] wdata_data,
    output logic                 wr_data,
    input  logic                 full_data,
    output logic [3:0]           tap_state,
    output logic                 capturing,
    output logic [15:0]          bit_count,
    output logic                 overflow
);

    localparam logic [3:0] TLR   = 4'd0;
    localparam logic [3:0] RTI   = 4'd1;
    localparam logic [3:0] SELDR = 4'd2;
    localparam logic [3:0] CAPDR = 4'd3;
    localparam logic [3:0] SHDR  = 4'd4;
    localparam logic [3:0] EX1DR = 4'd5;
    localparam logic [3:0] PDR   = 4'd6;
    localparam logic [3:0] EX2DR = 4'd7;
    localparam logic [3:0] UPDR  = 4'd8;
    localparam logic [3:0] SELIR = 4'd9;
    localparam logic [3:0] CAPIR = 4'd10;
    localparam logic [3:0] SHIR  = 4'd11;
    localparam logic [3:0] EX1IR = 4'd12;
    localparam logic [3:0] PIR   = 4'd13;
    localparam logic [3:0] EX2IR = 4'd14;
    localparam logic [3:0] UPIR  = 4'd15;

    localparam logic [3:0] RST_ST = (INIT_RTI != 0) ? RTI : TLR;
    localparam int IW = $clog2(DATA_DATA) + 1;
    localparam logic [IW-1:0] WLEN = IW'(DATA_DATA);

    logic                 tck_q, tck_qq, tms_q, tdo_q;
    logic [3:0]           state_q, state_d, state_nx;
    logic [DATA_DATA-1:0] word_q, word_d, wdata_q, wdata_d;
    logic [DATA_DATA-1:0] shifted;
    logic [DATA_DATA:0]   shift_ext;
    logic [IW-1:0]        idx_q, idx_d, idx_n;
    logic [15:0]          cnt_q, cnt_d;
    logic                 ovf_q, ovf_d, wr_q, wr_d;
    logic                 rise, in_shift, cap, full_word;

    assign rise = tck_q & ~tck_qq;

`ifdef CAPTURE_IR_EN
    assign in_shift = (state_q == SHDR) || (state_q == SHIR);
`else
    assign in_shift = (state_q == SHDR);
`endif

    assign cap       = rise & in_shift;
    assign shift_ext = {word_q, tdo_q};
    assign shifted   = shift_ext[DATA_DATA-1:0];
    assign idx_n     = idx_q + 1'b1;
    assign full_word = (idx_n == WLEN);

    always_comb begin
        state_nx = state_q;
        case (state_q)
            TLR:   state_nx = tms_q ? TLR   : RTI;
            RTI:   state_nx = tms_q ? SELDR : RTI;
            SELDR: state_nx = tms_q ? SELIR : CAPDR;
            CAPDR: state_nx = tms_q ? EX1DR : SHDR;
            SHDR:  state_nx = tms_q ? EX1DR : SHDR;
            EX1DR: state_nx = tms_q ? UPDR  : PDR;
            PDR:   state_nx = tms_q ? EX2DR : PDR;
            EX2DR: state_nx = tms_q ? UPDR  : SHDR;
            UPDR:  state_nx = tms_q ? SELDR : RTI;
            SELIR: state_nx = tms_q ? TLR   : CAPIR;
            CAPIR: state_nx = tms_q ? EX1IR : SHIR;
            SHIR:  state_nx = tms_q ? EX1IR : SHIR;
            EX1IR: state_nx = tms_q ? UPIR  : PIR;
            PIR:   state_nx = tms_q ? EX2IR : PIR;
            EX2IR: state_nx = tms_q ? UPIR  : SHIR;
            UPIR:  state_nx = tms_q ? SELDR : RTI;
            default: state_nx = TLR;
        endcase
    end

    always_comb begin
        state_d = rise ? state_nx : state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        wr_d    = 1'b0;
        wdata_d = wdata_q;
        if (clr) begin
            // clr wins over a coincident capture; only the TAP keeps moving
            word_d = '0;
            idx_d  = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
        end else if (cap) begin
            cnt_d = cnt_q + 16'd1;
            // tms_q high on a capture edge means we are leaving the shift state
            if (full_word || tms_q) begin
                word_d = '0;
                idx_d  = '0;
                if (full_data) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_d    = 1'b1;
                    wdata_d = shifted << (WLEN - idx_n);
                end
            end else begin
                word_d = shifted;
                idx_d  = idx_n;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tck_q   <= 1'b0;
            tck_qq  <= 1'b0;
            tms_q   <= 1'b0;
            tdo_q   <= 1'b0;
            state_q <= RST_ST;
            word_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            tck_q   <= tck;
            tck_qq  <= tck_q;
            tms_q   <= tms;
            tdo_q   <= tdo;
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    assign tap_state  = state_q;
    assign bit_count  = cnt_q;
    assign overflow   = ovf_q;
    assign wr_data    = wr_q;
    assign wdata_data = wdata_q;

`ifdef CAPTURE_IR_EN
    assign capturing = (state_q == SHDR) || (state_q == SHIR);
`else
    assign capturing = (state_q == SHDR);
`endif

endmodule

// File: tb/tb_jtag_tdo_capture.sv
// tb_jtag_tdo_capture: directed bench for jtag_tdo_capture with a scoreboard
// queue of expected FIFO words checked by a write-strobe monitor.
module tb_jtag_tdo_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tck = 1'b0;
    logic       tms = 1'b0;
    logic       tdo = 1'b0;
    logic       clr = 1'b0;
    logic       full_data = 1'b0;
    logic [7:0] wdata_data;
    logic       wr_data;
    logic [3:0] tap_state;
    logic       capturing;
    logic [15:0] bit_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int wr_seen = 0;
    int wr_exp = 0;
    logic [7:0] sb[$];

    jtag_tdo_capture #(.DATA_DATA(8), .INIT_RTI(1)) dut (
        .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdo(tdo), .clr(clr),
        .wdata_data(wdata_data), .wr_data(wr_data), .full_data(full_data),
        .tap_state(tap_state), .capturing(capturing),
        .bit_count(bit_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard monitor: every write strobe must match the oldest expectation
    always @(negedge clk) begin
        if (rst && wr_data) begin
            wr_seen++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $error("FAIL wr_unexpected observed=%0h expected=none",
                       wdata_data);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                assert (wdata_data === e) else begin
                    errors++;
                    $error("FAIL wdata observed=%0h expected=%0h",
                           wdata_data, e);
                end
            end
        end
    end

    task automatic edge_(input logic t, input logic d);
        @(negedge clk);
        tck = 1'b1; tms = t; tdo = d;
        repeat (2) @(negedge clk);
        tck = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic shift8(input logic [7:0] v, input logic last_tms);
        for (int i = 7; i >= 0; i--)
            edge_((i == 0) ? last_tms : 1'b0, v[i]);
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    // EX1DR -> PDR -> EX2DR -> SHDR
    task automatic back_to_shdr();
        edge_(1'b0, 1'b0);
        edge_(1'b1, 1'b0);
        edge_(1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tap", tap_state, 4'd1);
        chk("rst_cap", capturing, 1'b0);
        chk("rst_cnt", bit_count, 16'd0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_wr", wr_data, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // RTI -> SELDR -> CAPDR, then watch latency into SHDR
        edge_(1'b1, 1'b0);
        chk("tap_seldr", tap_state, 4'd2);
        edge_(1'b0, 1'b0);
        chk("tap_capdr", tap_state, 4'd3);
        @(negedge clk);
        tck = 1'b1; tms = 1'b0;
        @(negedge clk);
        chk("lat_before", tap_state, 4'd3);
        @(negedge clk);
        chk("lat_after", tap_state, 4'd4);
        chk("capturing_dr", capturing, 1'b1);
        tck = 1'b0;
        repeat (2) @(negedge clk);

        // full word, exiting on the last bit
        sb.push_back(8'hB2); wr_exp++;
        shift8(8'hB2, 1'b1);
        chk("cnt_8", bit_count, 16'd8);
        chk("tap_ex1dr", tap_state, 4'd5);
        chk("wr_cnt_1", wr_seen, wr_exp);

        // partial flush
        back_to_shdr();
        pulse_clr();
        chk("clr_cnt", bit_count, 16'd0);
        sb.push_back(8'hC0); wr_exp++;
        edge_(1'b0, 1'b1);
        edge_(1'b0, 1'b1);
        edge_(1'b1, 1'b0);
        chk("cnt_3", bit_count, 16'd3);
        chk("wr_cnt_2", wr_seen, wr_exp);

        // FIFO full: word dropped, sticky overflow
        back_to_shdr();
        full_data = 1'b1;
        shift8(8'hFF, 1'b0);
        chk("wr_cnt_full", wr_seen, wr_exp);
        chk("ovf_set", overflow, 1'b1);
        full_data = 1'b0;
        repeat (3) @(negedge clk);
        chk("ovf_sticky", overflow, 1'b1);
        pulse_clr();
        chk("ovf_clr", overflow, 1'b0);
        sb.push_back(8'h5A); wr_exp++;
        shift8(8'h5A, 1'b1);
        chk("wr_cnt_after_full", wr_seen, wr_exp);
        chk("cnt_after_full", bit_count, 16'd8);

        // clr coincident with the 8th-bit rise
        back_to_shdr();
        for (int i = 0; i < 7; i++) edge_(1'b0, 1'b1);
        chk("cnt_15", bit_count, 16'd15);
        @(negedge clk);
        tck = 1'b1; tms = 1'b1; tdo = 1'b1;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        tck = 1'b0;
        repeat (3) @(negedge clk);
        chk("clr_rise_cnt", bit_count, 16'd0);
        chk("clr_rise_tap", tap_state, 4'd5);
        chk("clr_rise_wr", wr_seen, wr_exp);

        // EX1DR -> UPDR -> SELDR -> SELIR -> CAPIR -> SHIR
        edge_(1'b1, 1'b0);
        edge_(1'b1, 1'b0);
        edge_(1'b1, 1'b0);
        edge_(1'b0, 1'b0);
        edge_(1'b0, 1'b0);
        chk("tap_shir", tap_state, 4'd11);
`ifdef CAPTURE_IR_EN
        chk("capturing_ir", capturing, 1'b1);
        sb.push_back(8'h3C); wr_exp++;
        sb.push_back(8'h80); wr_exp++;
`else
        chk("capturing_ir", capturing, 1'b0);
`endif
        shift8(8'h3C, 1'b0);
        chk("wr_cnt_ir", wr_seen, wr_exp);
        for (int i = 0; i < 5; i++) edge_(1'b1, 1'b1);
        chk("tap_tlr", tap_state, 4'd0);
        chk("wr_cnt_ir_exit", wr_seen, wr_exp);

        // async reset in the middle of a shift
        edge_(1'b0, 1'b0);
        edge_(1'b1, 1'b0);
        edge_(1'b0, 1'b0);
        edge_(1'b0, 1'b0);
        edge_(1'b0, 1'b1);
        edge_(1'b0, 1'b1);
        chk("mid_cap", capturing, 1'b1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_tap", tap_state, 4'd1);
        chk("mid_rst_cnt", bit_count, 16'd0);
        chk("mid_rst_cap", capturing, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("final_wr_cnt", wr_seen, wr_exp);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
